icache_fifo: RTL and testbench

Parameterized set-associative read-only instruction cache with FIFO replacement per set. It sits between the fetch stage, which presents `instr_addr`, and the instruction memory port (`mem_*`). It looks up every cycle, refills missing blocks word by word from memory, and reports each completed lookup with a one-cycle `hit` or `miss` pulse carrying the fetched instruction.

---
 rtl/icache_fifo.sv | 186 ++++++++++++++++++
 tb/tb_icache_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fifo.sv
// Set-associative read-only instruction cache with per-set FIFO replacement and word-by-word refill.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_fifo #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int WORD_SIZE         = 4,
  parameter int BLOCK_SIZE        = 1,
  parameter int DEG_ASSOCIATIVITY = 1,
  parameter int CAPACITY          = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  hit,
  output logic                  miss,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic [DATA_WIDTH-1:0] mem_instr,
  input  logic                  mem_instr_valid,
  output logic                  dbg_state_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int WOFF_W   = $clog2(WORD_SIZE);
  localparam int OFFSET_W = $clog2(WORD_SIZE * BLOCK_SIZE);
  localparam int SETS     = CAPACITY / (WORD_SIZE * BLOCK_SIZE * DEG_ASSOCIATIVITY);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int BEAT_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int WAY_W    = (DEG_ASSOCIATIVITY > 1) ? $clog2(DEG_ASSOCIATIVITY) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_e;
  state_e state_q, state_d;

  logic                  valid_q [SETS][DEG_ASSOCIATIVITY];
  logic [TAG_W-1:0]      tag_q   [SETS][DEG_ASSOCIATIVITY];
  logic [DATA_WIDTH-1:0] data_q  [SETS][DEG_ASSOCIATIVITY][BLOCK_SIZE];
  logic [WAY_W-1:0]      fifo_q  [SETS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  hit_q, miss_q;
  logic [DATA_WIDTH-1:0] instr_q;

  function automatic logic [BEAT_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    if (BLOCK_SIZE > 1) return a[WOFF_W +: BEAT_W];
    else return '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  logic [INDEX_W-1:0]    lk_idx, r_idx;
  logic [TAG_W-1:0]      lk_tag, r_tag;
  logic [BEAT_W-1:0]     lk_word, r_word;
  logic [WAY_W-1:0]      victim;
  logic                  lookup_hit, last_beat, hit_d, miss_d;
  logic [DATA_WIDTH-1:0] lookup_word, refill_word;

  assign lk_idx  = instr_addr[OFFSET_W +: INDEX_W];
  assign lk_tag  = instr_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lk_word = word_of(instr_addr);
  assign r_idx   = addr_q[OFFSET_W +: INDEX_W];
  assign r_tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign r_word  = word_of(addr_q);
  assign victim  = fifo_q[r_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[WOFF_W-1:0], addr_q[WOFF_W-1:0]};

  always_comb begin
    lookup_hit  = 1'b0;
    lookup_word = '0;
    for (int w = 0; w < DEG_ASSOCIATIVITY; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lookup_hit  = 1'b1;
        lookup_word = data_q[lk_idx][w][lk_word];
      end
    end
  end

  assign last_beat   = (beat_q == BEAT_W'(BLOCK_SIZE - 1));
  // Earlier beats of the line are already in the array; the final beat is only on mem_instr.
  assign refill_word = (r_word == beat_q) ? mem_instr : data_q[r_idx][victim][r_word];
  assign hit_d       = (state_q == S_IDLE) && lookup_hit;
  assign miss_d      = (state_q == S_REFILL) && mem_instr_valid && last_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!lookup_hit) state_d = S_REFILL;
      S_REFILL: if (mem_instr_valid && last_beat) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Refill handshake: mem_req/mem_addr hold steady until memory pulses mem_instr_valid for
  // one cycle per beat; each pulse consumes the beat at mem_addr. Reset forces mem_req low.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (rst) begin
      case (state_q)
        S_IDLE: if (!lookup_hit) begin
          mem_req  = 1'b1;
          mem_addr = block_base(instr_addr);
        end
        S_REFILL: begin
          mem_req  = 1'b1;
          mem_addr = block_base(addr_q) + (ADDR_WIDTH'(beat_q) << WOFF_W);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        fifo_q[s] <= '0;
        for (int w = 0; w < DEG_ASSOCIATIVITY; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      if (state_q == S_IDLE) begin
        if (lookup_hit) begin
          instr_q <= lookup_word;
        end else begin
          addr_q <= instr_addr;
          beat_q <= '0;
        end
      end else if (mem_instr_valid) begin
        beat_q <= beat_q + 1'b1;
        if (last_beat) begin
          valid_q[r_idx][victim] <= 1'b1;
          fifo_q[r_idx]          <= (DEG_ASSOCIATIVITY > 1) ? victim + 1'b1 : '0;
          instr_q                <= refill_word;
          beat_q                 <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == S_REFILL) && mem_instr_valid) begin
      data_q[r_idx][victim][beat_q] <= mem_instr;
      if (last_beat) tag_q[r_idx][victim] <= r_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_d)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_d) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign instr       = instr_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_icache_fifo.sv
// Bench for icache_fifo: three instances (direct-mapped, 2-way, 4-word blocks) driven from a
// vector table, plus hand-written reset-during-refill and counter sequences.
module tb_icache_fifo;
  logic clk;
  logic rst;

  logic [31:0] addr_a   [3];
  logic [31:0] mdata_a  [3];
  logic        mvalid_a [3];
  wire  [31:0] instr_w  [3];
  wire  [31:0] maddr_w  [3];
  wire         hit_w    [3];
  wire         miss_w   [3];
  wire         mreq_w   [3];
  wire         dbg_w    [3];
`ifdef ICACHE_PERF_CNT_EN
  wire  [31:0] hcnt_w   [3];
  wire  [31:0] mcnt_w   [3];
`endif

  int checks   = 0;
  int failures = 0;

  icache_fifo u_dm (
    .clk(clk), .rst(rst), .instr_addr(addr_a[0]), .instr(instr_w[0]), .hit(hit_w[0]),
    .miss(miss_w[0]), .mem_addr(maddr_w[0]), .mem_req(mreq_w[0]), .mem_instr(mdata_a[0]),
    .mem_instr_valid(mvalid_a[0]), .dbg_state_o(dbg_w[0])
`ifdef ICACHE_PERF_CNT_EN
    , .hit_count(hcnt_w[0]), .miss_count(mcnt_w[0])
`endif
  );

  icache_fifo #(.DEG_ASSOCIATIVITY(2)) u_a2 (
    .clk(clk), .rst(rst), .instr_addr(addr_a[1]), .instr(instr_w[1]), .hit(hit_w[1]),
    .miss(miss_w[1]), .mem_addr(maddr_w[1]), .mem_req(mreq_w[1]), .mem_instr(mdata_a[1]),
    .mem_instr_valid(mvalid_a[1]), .dbg_state_o(dbg_w[1])
`ifdef ICACHE_PERF_CNT_EN
    , .hit_count(hcnt_w[1]), .miss_count(mcnt_w[1])
`endif
  );

  icache_fifo #(.BLOCK_SIZE(4)) u_b4 (
    .clk(clk), .rst(rst), .instr_addr(addr_a[2]), .instr(instr_w[2]), .hit(hit_w[2]),
    .miss(miss_w[2]), .mem_addr(maddr_w[2]), .mem_req(mreq_w[2]), .mem_instr(mdata_a[2]),
    .mem_instr_valid(mvalid_a[2]), .dbg_state_o(dbg_w[2])
`ifdef ICACHE_PERF_CNT_EN
    , .hit_count(hcnt_w[2]), .miss_count(mcnt_w[2])
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Memory contents: word at byte address a holds 0xA0000000 | (a >> 2)
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hA000_0000 | (a >> 2);
  endfunction

  function automatic int blk_of(input int s);
    return (s == 2) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reset all instances; leaves the bench just after a falling edge with rst released
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mvalid_a[s] = 1'b0;
      mdata_a[s]  = 32'hDEAD_BEEF;
    end
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst%0d_hit", s),   32'(hit_w[s]),  32'd0);
      chk($sformatf("rst%0d_miss", s),  32'(miss_w[s]), 32'd0);
      chk($sformatf("rst%0d_instr", s), instr_w[s],     32'd0);
      chk($sformatf("rst%0d_req", s),   32'(mreq_w[s]), 32'd0);
      chk($sformatf("rst%0d_maddr", s), maddr_w[s],     32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One lookup on instance s, entered and left just after a falling edge
  task automatic do_access(input int s, input logic [31:0] a, input bit exp_hit, input string name);
    logic [31:0] base;
    logic [31:0] exp_addr;
    int          nb;
    int          waits;
    nb   = blk_of(s);
    base = a & ~(32'(nb * 4) - 32'd1);
    addr_a[s] = a;
    #1;
    if (exp_hit) begin
      chk({name, "_req"}, 32'(mreq_w[s]), 32'd0);
      @(negedge clk);
      chk({name, "_hit"},   32'(hit_w[s]),  32'd1);
      chk({name, "_miss"},  32'(miss_w[s]), 32'd0);
      chk({name, "_instr"}, instr_w[s],     data_of(a));
    end else begin
      chk({name, "_req0"},   32'(mreq_w[s]), 32'd1);
      chk({name, "_maddr0"}, maddr_w[s],     base);
      @(negedge clk);
      for (int b = 0; b < nb; b++) begin
        exp_addr = base + 32'(b * 4);
        waits    = $urandom_range(0, 2);
        repeat (waits) begin
          chk($sformatf("%s_wait_req%0d", name, b),   32'(mreq_w[s]), 32'd1);
          chk($sformatf("%s_wait_maddr%0d", name, b), maddr_w[s],     exp_addr);
          @(negedge clk);
        end
        chk($sformatf("%s_req_b%0d", name, b),   32'(mreq_w[s]), 32'd1);
        chk($sformatf("%s_maddr_b%0d", name, b), maddr_w[s],     exp_addr);
        mdata_a[s]  = data_of(exp_addr);
        mvalid_a[s] = 1'b1;
        @(negedge clk);
        mvalid_a[s] = 1'b0;
        mdata_a[s]  = 32'hDEAD_BEEF;
        if (b != nb - 1) chk($sformatf("%s_early_miss%0d", name, b), 32'(miss_w[s]), 32'd0);
      end
      chk({name, "_miss"},  32'(miss_w[s]), 32'd1);
      chk({name, "_hit"},   32'(hit_w[s]),  32'd0);
      chk({name, "_instr"}, instr_w[s],     data_of(a));
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] addr;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // Vector table: instance, address, expected hit (0 = miss with refill)
    vecs[0]  = '{0, 32'h010, 1'b0};
    vecs[1]  = '{0, 32'h010, 1'b1};
    vecs[2]  = '{0, 32'h010, 1'b1};
    vecs[3]  = '{0, 32'h000, 1'b0};
    vecs[4]  = '{0, 32'h100, 1'b0};
    vecs[5]  = '{0, 32'h000, 1'b0};
    vecs[6]  = '{0, 32'h010, 1'b1};
    vecs[7]  = '{1, 32'h000, 1'b0};
    vecs[8]  = '{1, 32'h080, 1'b0};
    vecs[9]  = '{1, 32'h000, 1'b1};
    vecs[10] = '{1, 32'h100, 1'b0};
    vecs[11] = '{1, 32'h000, 1'b0};
    vecs[12] = '{1, 32'h080, 1'b0};
    vecs[13] = '{1, 32'h000, 1'b1};
    vecs[14] = '{2, 32'h018, 1'b0};
    vecs[15] = '{2, 32'h01C, 1'b1};
    vecs[16] = '{2, 32'h010, 1'b1};
    vecs[17] = '{2, 32'h014, 1'b1};
    vecs[18] = '{2, 32'h020, 1'b0};
    vecs[19] = '{2, 32'h018, 1'b1};

    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      addr_a[s]   = 32'h0;
      mdata_a[s]  = 32'hDEAD_BEEF;
      mvalid_a[s] = 1'b0;
    end

    for (int i = 0; i < 20; i++) begin
      if (i == 0 || vecs[i].sel != vecs[i-1].sel) do_reset();
      do_access(vecs[i].sel, vecs[i].addr, vecs[i].exp_hit, $sformatf("v%0d", i));
    end

    // Reset during a 4-beat refill: drops immediately and leaves no line behind
    do_reset();
    addr_a[2] = 32'h040;
    #1;
    chk("mr_req_start", 32'(mreq_w[2]), 32'd1);
    @(negedge clk);
    mdata_a[2]  = data_of(32'h040);
    mvalid_a[2] = 1'b1;
    @(negedge clk);
    mvalid_a[2] = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_req_async", 32'(mreq_w[2]), 32'd0);
    chk("mr_hit",       32'(hit_w[2]),  32'd0);
    chk("mr_miss",      32'(miss_w[2]), 32'd0);
    chk("mr_state",     32'(dbg_w[2]),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_access(2, 32'h040, 1'b0, "mr_again");
    do_access(2, 32'h04C, 1'b1, "mr_neighbor");

`ifdef ICACHE_PERF_CNT_EN
    do_reset();
    do_access(0, 32'h200, 1'b0, "pc_m0");
    do_access(0, 32'h204, 1'b0, "pc_m1");
    do_access(0, 32'h208, 1'b0, "pc_m2");
    do_access(0, 32'h200, 1'b1, "pc_h0");
    do_access(0, 32'h204, 1'b1, "pc_h1");
    chk("pc_miss_count", mcnt_w[0], 32'd3);
    chk("pc_hit_count",  hcnt_w[0], 32'd2);
    rst = 1'b0;
    #1;
    chk("pc_miss_clr", mcnt_w[0], 32'd0);
    chk("pc_hit_clr",  hcnt_w[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
